key_entry: RTL and testbench

KEY_ENTRY -- requirements
Module: key_entry

---
 rtl/key_entry_if.sv | 22 ++
 rtl/key_entry.sv | 188 ++++++++++++++++++
 tb/tb_key_entry.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/key_entry_if.sv
// Keypad-side and entry-store-side signals of the key entry block.
// The master modport is the key_entry side; slave is the keypad/store side.
interface key_entry_if;
    logic [3:0] row_in;
    logic [2:0] col_out;
    logic [3:0] Code_1;
    logic       write_en;
    logic [3:0] RAM_addr;
    logic       Valid_1;
    logic [2:0] digit_cnt;
    logic       overflow;

    modport master (
        input  row_in,
        output col_out, Code_1, write_en, RAM_addr, Valid_1, digit_cnt, overflow
    );

    modport slave (
        output row_in,
        input  col_out, Code_1, write_en, RAM_addr, Valid_1, digit_cnt, overflow
    );
endinterface

// File: rtl/key_entry.sv
// 4x3 keypad scanner with debounce that assembles up to four digits and a
// terminator (* or #) into an entry store, with an idle timeout on partial entries.
module key_entry #(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int TIMEOUT_CYCLES  = 50000000
) (
    input  logic         clk,
    input  logic         reset_1,
    key_entry_if.master  kp
);
    localparam int SCAN_W = $clog2(SCAN_DIV + 1);
    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {SCAN, DEBOUNCE, EMIT, VALID, RELEASE} state_t;

    state_t             state_reg, state_next;
    logic [1:0]         col_reg, col_next;
    logic [1:0]         row_sel_reg, row_sel_next;
    logic [SCAN_W-1:0]  scan_cnt_reg, scan_cnt_next;
    logic [DEB_W-1:0]   deb_cnt_reg, deb_cnt_next;
    logic [TMO_W-1:0]   tmo_cnt_reg, tmo_cnt_next;
    logic [3:0]         code_reg, code_next;
    logic [3:0]         addr_reg, addr_next;
    logic [2:0]         cnt_reg, cnt_next;

    logic [3:0]         row_low;
    logic [1:0]         first_row;
    logic               latched_low;
    logic [3:0]         key_code;
    logic               is_term;
    logic               can_write;

    for (genvar gi = 0; gi < 4; gi++) begin : g_row
        assign row_low[gi] = ~kp.row_in[gi];
    end

    // Column drive stays frozen outside SCAN because col_reg only advances there.
    for (genvar gi = 0; gi < 3; gi++) begin : g_col
        assign kp.col_out[gi] = (col_reg != 2'(gi));
    end

    assign latched_low  = row_low[row_sel_reg];
    assign is_term      = (row_sel_reg == 2'd3) && (col_reg != 2'd1);
    assign can_write    = is_term || (cnt_reg < 3'd4);
    assign kp.Code_1    = code_reg;
    assign kp.RAM_addr  = addr_reg;
    assign kp.digit_cnt = cnt_reg;

    // Lowest-index low row wins when several rows are pulled low together.
    always_comb begin
        first_row = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (row_low[i]) first_row = 2'(i);
        end
    end

    always_comb begin
        key_code = 4'd0;
        if (row_sel_reg != 2'd3) begin
            key_code = {2'b00, row_sel_reg} * 4'd3 + {2'b00, col_reg} + 4'd1;
        end else begin
            case (col_reg)
                2'd0:    key_code = 4'b1010;
                2'd1:    key_code = 4'b0000;
                default: key_code = 4'b1011;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset_1) begin
        if (reset_1) begin
            state_reg    <= SCAN;
            col_reg      <= 2'd0;
            row_sel_reg  <= 2'd0;
            scan_cnt_reg <= '0;
            deb_cnt_reg  <= '0;
            tmo_cnt_reg  <= '0;
            code_reg     <= 4'd0;
            addr_reg     <= 4'd0;
            cnt_reg      <= 3'd0;
        end else begin
            state_reg    <= state_next;
            col_reg      <= col_next;
            row_sel_reg  <= row_sel_next;
            scan_cnt_reg <= scan_cnt_next;
            deb_cnt_reg  <= deb_cnt_next;
            tmo_cnt_reg  <= tmo_cnt_next;
            code_reg     <= code_next;
            addr_reg     <= addr_next;
            cnt_reg      <= cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        col_next      = col_reg;
        row_sel_next  = row_sel_reg;
        scan_cnt_next = scan_cnt_reg;
        deb_cnt_next  = deb_cnt_reg;
        tmo_cnt_next  = '0;
        code_next     = code_reg;
        addr_next     = addr_reg;
        cnt_next      = cnt_reg;

        case (state_reg)
            SCAN: begin
                if (|row_low) begin
                    row_sel_next  = first_row;
                    deb_cnt_next  = '0;
                    scan_cnt_next = '0;
                    state_next    = DEBOUNCE;
                end else begin
                    if (scan_cnt_reg == SCAN_W'(SCAN_DIV - 1)) begin
                        scan_cnt_next = '0;
                        col_next      = (col_reg == 2'd2) ? 2'd0 : col_reg + 2'd1;
                    end else begin
                        scan_cnt_next = scan_cnt_reg + 1'b1;
                    end
                    // Idle time only accumulates while a partial entry is held.
                    if (cnt_reg != 3'd0) begin
                        if (tmo_cnt_reg == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                            cnt_next = 3'd0;
                        end else begin
                            tmo_cnt_next = tmo_cnt_reg + 1'b1;
                        end
                    end
                end
            end
            DEBOUNCE: begin
                if (!latched_low) begin
                    deb_cnt_next = '0;
                    state_next   = SCAN;
                end else if (deb_cnt_reg == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
                    deb_cnt_next = '0;
                    state_next   = EMIT;
                    if (can_write) begin
                        code_next = key_code;
                        addr_next = is_term ? 4'd0 : {1'b0, cnt_reg} + 4'd1;
                    end
                end else begin
                    deb_cnt_next = deb_cnt_reg + 1'b1;
                end
            end
            EMIT: begin
                deb_cnt_next = '0;
                if (is_term) begin
                    state_next = VALID;
                end else begin
                    if (cnt_reg < 3'd4) cnt_next = cnt_reg + 3'd1;
                    state_next = RELEASE;
                end
            end
            VALID: begin
                cnt_next     = 3'd0;
                deb_cnt_next = '0;
                state_next   = RELEASE;
            end
            RELEASE: begin
                if (|row_low) begin
                    deb_cnt_next = '0;
                end else if (deb_cnt_reg == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
                    deb_cnt_next  = '0;
                    scan_cnt_next = '0;
                    state_next    = SCAN;
                end else begin
                    deb_cnt_next = deb_cnt_reg + 1'b1;
                end
            end
            default: state_next = SCAN;
        endcase
    end

    always_comb begin
        kp.write_en = 1'b0;
        kp.overflow = 1'b0;
        kp.Valid_1  = 1'b0;
        case (state_reg)
            EMIT: begin
                kp.write_en = can_write;
                kp.overflow = ~can_write;
            end
            VALID:   kp.Valid_1 = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_key_entry.sv
// Self-checking bench for key_entry: keypad model, key-map table, directed
// corner sequences and randomized presses against an entry-level reference model.
module tb_key_entry;
    localparam int SCAN_DIV = 2;
    localparam int DEB      = 4;
    localparam int TMO      = 200;

    logic clk = 1'b0;
    logic reset_1 = 1'b1;
    logic [11:0] key_down = '0;

    key_entry_if kif();

    key_entry #(
        .SCAN_DIV(SCAN_DIV),
        .DEBOUNCE_CYCLES(DEB),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .reset_1(reset_1),
        .kp(kif.master)
    );

    always #5 clk = ~clk;

    // Physical keypad: a held key pulls its row low only while its column is driven.
    always_comb begin
        logic [3:0] rows;
        rows = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                if (key_down[r*3+c] && !kif.col_out[c]) rows[r] = 1'b0;
        kif.row_in = rows;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int key_val(int r, int c);
        int map [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 0, 11};
        return map[r*3+c];
    endfunction

    // Observed transactions.
    int w_addr[$];
    int w_code[$];
    int ovf_seen = 0;
    int valid_seen = 0;
    logic prev_term = 1'b0;
    logic [3:0] prev_code = 4'd0;

    always @(negedge clk) begin
        int ns;
        ns = int'(kif.write_en) + int'(kif.Valid_1) + int'(kif.overflow);
        if (ns > 0) check("strobe_exclusive", ns, 1);
        if (prev_term) begin
            check("valid_after_term", int'(kif.Valid_1), 1);
            check("valid_code_hold", int'(kif.Code_1), int'(prev_code));
        end else if (kif.Valid_1) begin
            check("valid_orphan", int'(kif.Valid_1), 0);
        end
        if (kif.write_en) begin
            w_addr.push_back(int'(kif.RAM_addr));
            w_code.push_back(int'(kif.Code_1));
            $display("write addr=%0d code=%b", kif.RAM_addr, kif.Code_1);
        end
        if (kif.overflow) ovf_seen++;
        if (kif.Valid_1) valid_seen++;
        prev_term = kif.write_en && (kif.RAM_addr == 4'd0);
        prev_code = kif.Code_1;
    end

    // Reference model: entry rules on whole key presses.
    int exp_addr[$];
    int exp_code[$];
    int exp_ovf = 0;
    int exp_valid = 0;
    int m_cnt = 0;

    task automatic model_key(int r, int c);
        int k;
        k = key_val(r, c);
        if (k >= 10) begin
            exp_addr.push_back(0);
            exp_code.push_back(k);
            exp_valid++;
            m_cnt = 0;
        end else if (m_cnt < 4) begin
            m_cnt++;
            exp_addr.push_back(m_cnt);
            exp_code.push_back(k);
        end else begin
            exp_ovf++;
        end
    endtask

    task automatic model_idle(int cycles);
        if (cycles > TMO + 20) m_cnt = 0;
    endtask

    task automatic verify(string name);
        int n;
        check({name, "_nwrites"}, w_addr.size(), exp_addr.size());
        n = (w_addr.size() < exp_addr.size()) ? w_addr.size() : exp_addr.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_addr%0d", name, i), w_addr[i], exp_addr[i]);
            check($sformatf("%s_code%0d", name, i), w_code[i], exp_code[i]);
        end
        check({name, "_overflow"}, ovf_seen, exp_ovf);
        check({name, "_valid"}, valid_seen, exp_valid);
        check({name, "_digit_cnt"}, int'(kif.digit_cnt), m_cnt);
        w_addr.delete(); w_code.delete(); exp_addr.delete(); exp_code.delete();
        ovf_seen = 0; valid_seen = 0; exp_ovf = 0; exp_valid = 0;
    endtask

    task automatic press(int r, int c, int hold, int gap);
        key_down[r*3+c] = 1'b1;
        repeat (hold) @(posedge clk);
        #1 key_down = '0;
        repeat (gap) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(string name);
        check({name, "_col_out"}, int'(kif.col_out), 6);
        check({name, "_code"}, int'(kif.Code_1), 0);
        check({name, "_addr"}, int'(kif.RAM_addr), 0);
        check({name, "_write_en"}, int'(kif.write_en), 0);
        check({name, "_valid"}, int'(kif.Valid_1), 0);
        check({name, "_overflow"}, int'(kif.overflow), 0);
        check({name, "_digit_cnt"}, int'(kif.digit_cnt), 0);
    endtask

    typedef struct {
        int r; int c;
        int n_wr; int code; int addr; int ovf; int vld; int cnt;
    } vec_t;

    vec_t tbl [12];

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Every key once, in map order; Code_1/RAM_addr columns are values held after the press.
        tbl[0]  = '{0, 0, 1, 1,  1, 0, 0, 1};
        tbl[1]  = '{0, 1, 1, 2,  2, 0, 0, 2};
        tbl[2]  = '{0, 2, 1, 3,  3, 0, 0, 3};
        tbl[3]  = '{1, 0, 1, 4,  4, 0, 0, 4};
        tbl[4]  = '{1, 1, 0, 4,  4, 1, 0, 4};
        tbl[5]  = '{1, 2, 0, 4,  4, 1, 0, 4};
        tbl[6]  = '{2, 0, 0, 4,  4, 1, 0, 4};
        tbl[7]  = '{2, 1, 0, 4,  4, 1, 0, 4};
        tbl[8]  = '{2, 2, 0, 4,  4, 1, 0, 4};
        tbl[9]  = '{3, 0, 1, 10, 0, 0, 1, 0};
        tbl[10] = '{3, 1, 1, 0,  1, 0, 0, 1};
        tbl[11] = '{3, 2, 1, 11, 0, 0, 1, 0};

        #2 check_reset_values("reset");
        repeat (3) @(posedge clk);
        #1 reset_1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) begin
            int nw, no, nv;
            nw = w_addr.size(); no = ovf_seen; nv = valid_seen;
            press(tbl[i].r, tbl[i].c, 10, 10);
            check($sformatf("tbl%0d_writes", i), w_addr.size() - nw, tbl[i].n_wr);
            check($sformatf("tbl%0d_code", i), int'(kif.Code_1), tbl[i].code);
            check($sformatf("tbl%0d_addr", i), int'(kif.RAM_addr), tbl[i].addr);
            check($sformatf("tbl%0d_ovf", i), ovf_seen - no, tbl[i].ovf);
            check($sformatf("tbl%0d_valid", i), valid_seen - nv, tbl[i].vld);
            check($sformatf("tbl%0d_cnt", i), int'(kif.digit_cnt), tbl[i].cnt);
        end
        w_addr.delete(); w_code.delete(); ovf_seen = 0; valid_seen = 0; m_cnt = 0;

        // 1,2,3,4,# with 10-cycle holds and gaps.
        press(0, 0, 10, 10); model_key(0, 0);
        press(0, 1, 10, 10); model_key(0, 1);
        press(0, 2, 10, 10); model_key(0, 2);
        press(1, 0, 10, 10); model_key(1, 0);
        press(3, 2, 10, 10); model_key(3, 2);
        verify("seq1234");

        // Bouncy press of 5 yields a single write.
        key_down[4] = 1'b1; repeat (2) @(posedge clk);
        #1 key_down[4] = 1'b0; @(posedge clk);
        #1 key_down[4] = 1'b1; repeat (10) @(posedge clk);
        #1 key_down = '0; repeat (10) @(posedge clk);
        #1 model_key(1, 1);
        press(3, 2, 10, 10); model_key(3, 2);
        verify("bounce");

        // Rows 0 and 2 pressed together in column 1.
        key_down[1] = 1'b1; key_down[7] = 1'b1;
        repeat (12) @(posedge clk);
        #1 key_down = '0; repeat (10) @(posedge clk);
        #1 model_key(0, 1);
        press(3, 2, 10, 10); model_key(3, 2);
        verify("multirow");

        // Partial entry discarded after idling past the timeout.
        press(2, 0, 10, 250); model_key(2, 0); model_idle(250);
        check("timeout_cnt", int'(kif.digit_cnt), 0);
        press(3, 2, 10, 10); model_key(3, 2);
        verify("timeout");

        // Random key sequences, with occasional long idles.
        for (int i = 0; i < 40; i++) begin
            int r, c, hold, gap;
            r = $urandom_range(3, 0);
            c = $urandom_range(2, 0);
            hold = $urandom_range(16, 10);
            gap = ($urandom_range(7, 0) == 0) ? $urandom_range(300, 260) : $urandom_range(25, 10);
            press(r, c, hold, gap);
            model_key(r, c);
            model_idle(gap);
        end
        verify("random");

        // Reset in the middle of debouncing digit 9.
        press(0, 0, 10, 10); model_key(0, 0);
        verify("pre_reset");
        key_down[8] = 1'b1;
        begin
            int waited;
            waited = 0;
            while (kif.col_out != 3'b011 && waited < 30) begin
                @(posedge clk); #1;
                waited++;
            end
            check("reach_col2", int'(kif.col_out), 3);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_1 = 1'b1;
        #1 check_reset_values("midreset");
        repeat (3) @(posedge clk);
        #1 key_down = '0;
        @(posedge clk);
        #1 reset_1 = 1'b0;
        #1 check("restart_col", int'(kif.col_out), 6);
        repeat (20) @(posedge clk);
        #1 m_cnt = 0;
        verify("reset_abort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
